// File: rtl/pulse_pkg.sv
// Shared types and defaults for the pulse burst scheduler.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RUN,
        DONE
    } pulse_sched_state_t;

    localparam int unsigned CNT_W_DEFAULT = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first request strictly after the pointer wins.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]         o_win_oh,
    output logic [$clog2(NUM_REQ)-1:0] o_win_idx
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_win_oh  = '0;
        o_win_idx = '0;
        w_sum     = '0;
        w_cand    = '0;
        w_found   = 1'b0;
        // Walk pointer+1 .. pointer+NUM_REQ, wrapping modulo NUM_REQ.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(i);
            if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_win_oh[w_cand] = 1'b1;
                o_win_idx        = w_cand;
            end
        end
    end

endmodule

// File: rtl/pulse_burst_sched.sv
// Round-robin scheduler sharing one pulse-burst generator between NUM_REQ requesters.
module pulse_burst_sched
    import pulse_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*CNT_W-1:0]     i_req_period,
    input  logic [NUM_REQ*CNT_W-1:0]     i_req_count,
    input  logic                         i_abort,
    output logic [NUM_REQ-1:0]           o_grant,
    output logic [NUM_REQ-1:0]           o_done,
    output logic                         o_aborted,
    output logic                         o_busy,
    output logic [$clog2(NUM_REQ)-1:0]   o_owner,
    output logic                         o_pulse,
    output logic [CNT_W-1:0]             o_clk_count,
    output logic [CNT_W-1:0]             o_pulse_count
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    pulse_sched_state_t r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_period;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_clk_count;
    logic [CNT_W-1:0]   r_pulse_count;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_done;
    logic               r_aborted;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_win_oh;
    logic [IDX_W-1:0]   w_win_idx;
    logic [CNT_W-1:0]   w_sel_period;
    logic [CNT_W-1:0]   w_sel_count;
    logic [NUM_REQ-1:0] w_owner_oh;
    logic               w_pulse;
    logic               w_last_phase;
    logic [CNT_W-1:0]   w_pc_next;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .i_req     (i_req),
        .i_ptr     (r_ptr),
        .o_win_oh  (w_win_oh),
        .o_win_idx (w_win_idx)
    );

    always_comb begin
        w_sel_period = '0;
        w_sel_count  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win_oh[i]) begin
                w_sel_period = i_req_period[i*CNT_W +: CNT_W];
                w_sel_count  = i_req_count[i*CNT_W +: CNT_W];
            end
        end
    end

    assign w_owner_oh   = NUM_REQ'(1) << r_owner;
    assign w_pulse      = (r_state == RUN) && (r_clk_count == '0);
    assign w_last_phase = (r_clk_count == r_period - CNT_W'(1));
    // Count including a pulse emitted this cycle, so P=1 bursts stop on time.
    assign w_pc_next    = r_pulse_count + CNT_W'(w_pulse);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_ptr         <= IDX_W'(NUM_REQ - 1);
            r_owner       <= '0;
            r_period      <= '0;
            r_count       <= '0;
            r_clk_count   <= '0;
            r_pulse_count <= '0;
            r_grant       <= '0;
            r_done        <= '0;
            r_aborted     <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_grant   <= '0;
            r_done    <= '0;
            r_aborted <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_state       <= GRANT;
                        r_owner       <= w_win_idx;
                        r_ptr         <= w_win_idx;
                        r_period      <= (w_sel_period == '0) ? CNT_W'(1) : w_sel_period;
                        r_count       <= w_sel_count;
                        r_grant       <= w_win_oh;
                        r_busy        <= 1'b1;
                        r_clk_count   <= '0;
                        r_pulse_count <= '0;
                    end
                end
                GRANT: begin
                    if ((r_count == '0) || i_abort) begin
                        r_state   <= DONE;
                        r_done    <= w_owner_oh;
                        r_aborted <= i_abort;
                    end else begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_pulse_count <= w_pc_next;
                    r_clk_count   <= w_last_phase ? '0 : r_clk_count + CNT_W'(1);
                    if (i_abort || (w_last_phase && (w_pc_next == r_count))) begin
                        r_state   <= DONE;
                        r_done    <= w_owner_oh;
                        r_aborted <= i_abort;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_done        = r_done;
    assign o_aborted     = r_aborted;
    assign o_busy        = r_busy;
    assign o_owner       = r_owner;
    assign o_pulse       = w_pulse;
    assign o_clk_count   = r_clk_count;
    assign o_pulse_count = r_pulse_count;

endmodule
